// File: rtl/mem_loader.sv
// Streams host words into consecutive RAM addresses via the override port while holding the CPU.
// Two cycles minimum per word (accept, write); host stalls via in_ready, RAM stalls via memory_done with timeout.
module mem_loader #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 9,
   parameter int DONE_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  mem_overide,
   output logic                  mem_write,
   output logic                  mem_enable,
   output logic [ADDR_WIDTH-1:0] overide_address,
   output logic [DATA_WIDTH-1:0] overide_data_in,
   input  logic                  memory_done,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  load_done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   words_written
);

   localparam int TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
   localparam logic [TW-1:0]       TMO_LAST  = TW'(DONE_TIMEOUT - 1);
   localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] ONE_WORD  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_WRITE,
      S_FINISH,
      S_ERROR
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
   logic [ADDR_WIDTH:0]     written_q, written_d;
   logic [TW-1:0]           tmo_q, tmo_d;
   logic [ADDR_WIDTH:0]     clamped_count;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      remaining_d = remaining_q;
      written_d   = written_q;
      tmo_d       = tmo_q;
      clamped_count = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;

      case (state_q)
         S_IDLE, S_ERROR: begin
            // A restart from ERROR behaves exactly like a start from IDLE.
            if (start) begin
               written_d = '0;
               if (clamped_count == '0) begin
                  state_d = S_FINISH;
               end else begin
                  addr_d      = base_addr;
                  remaining_d = clamped_count;
                  state_d     = S_ACCEPT;
               end
            end
         end
         S_ACCEPT: begin
            if (in_valid) begin
               data_d  = in_data;
               tmo_d   = '0;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (memory_done) begin
               addr_d      = addr_q + 1'b1;
               written_d   = written_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               state_d     = (remaining_q == ONE_WORD) ? S_FINISH : S_ACCEPT;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_ERROR;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         data_q      <= '0;
         remaining_q <= '0;
         written_q   <= '0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         remaining_q <= remaining_d;
         written_q   <= written_d;
         tmo_q       <= tmo_d;
      end
   end

   // Outputs decode the state register only, so none of them depend combinationally on inputs.
   assign in_ready        = (state_q == S_ACCEPT);
   assign mem_overide     = (state_q == S_WRITE);
   assign mem_write       = (state_q == S_WRITE);
   assign mem_enable      = (state_q == S_WRITE);
   assign overide_address = (state_q == S_WRITE) ? addr_q : '0;
   assign overide_data_in = (state_q == S_WRITE) ? data_q : '0;
   assign cpu_hold        = (state_q != S_IDLE);
   assign busy            = (state_q == S_ACCEPT) || (state_q == S_WRITE);
   assign load_done       = (state_q == S_FINISH);
   assign error           = (state_q == S_ERROR);
   assign words_written   = written_q;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: per-load cycle timelines are derived from host/RAM delays and compared every cycle.
module tb_mem_loader;
   localparam int AW = 9;
   localparam int DW = 32;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          clear, start, in_valid, memory_done;
   logic [AW-1:0] base_addr;
   logic [AW:0]   word_count;
   logic [DW-1:0] in_data;
   logic          in_ready, mem_overide, mem_write, mem_enable;
   logic [AW-1:0] overide_address;
   logic [DW-1:0] overide_data_in;
   logic          cpu_hold, busy, load_done, error;
   logic [AW:0]   words_written;

   always #5 clk = ~clk;

   mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DONE_TIMEOUT(TO)) dut (
      .clk(clk), .clear(clear), .start(start), .base_addr(base_addr),
      .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_overide(mem_overide), .mem_write(mem_write),
      .mem_enable(mem_enable), .overide_address(overide_address),
      .overide_data_in(overide_data_in), .memory_done(memory_done),
      .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done), .error(error),
      .words_written(words_written)
   );

   typedef struct packed {
      logic        clr;
      logic        start;
      logic [8:0]  base;
      logic [9:0]  cnt;
      logic        vld;
      logic [31:0] dat;
      logic        done;
   } stim_t;

   typedef struct packed {
      logic        chk;
      logic        rdy;
      logic        mem;
      logic [8:0]  addr;
      logic [31:0] data;
      logic        hold;
      logic        busy;
      logic        ld;
      logic        err;
      logic [9:0]  ww;
   } exp_t;

   stim_t       sq[$];
   exp_t        eq[$];
   exp_t        cur_exp;
   bit          chk_en = 1'b0;
   int          checks = 0;
   int          errors = 0;
   int          ld_seen = 0;
   int          mw_seen = 0;
   int          nwrites = 0;
   bit          m_err = 1'b0;
   int          m_ww = 0;
   logic [31:0] ram[512];
   logic [31:0] exp_ram[512];
   int          hd_q[$];
   int          lat_q[$];
   logic [31:0] w_q[$];

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && cur_exp.chk) begin
         check("in_ready",        64'(in_ready),        64'(cur_exp.rdy));
         check("mem_overide",     64'(mem_overide),     64'(cur_exp.mem));
         check("mem_write",       64'(mem_write),       64'(cur_exp.mem));
         check("mem_enable",      64'(mem_enable),      64'(cur_exp.mem));
         check("overide_address", 64'(overide_address), 64'(cur_exp.addr));
         check("overide_data_in", 64'(overide_data_in), 64'(cur_exp.data));
         check("cpu_hold",        64'(cpu_hold),        64'(cur_exp.hold));
         check("busy",            64'(busy),            64'(cur_exp.busy));
         check("load_done",       64'(load_done),       64'(cur_exp.ld));
         check("error",           64'(error),           64'(cur_exp.err));
         check("words_written",   64'(words_written),   64'(cur_exp.ww));
      end
      if (load_done === 1'b1) ld_seen++;
      if (mem_write === 1'b1) mw_seen++;
   end

   // Physical RAM: a word lands when the write strobe meets the RAM's completion.
   always @(posedge clk) begin
      if (clear !== 1'b1 && mem_write === 1'b1 && memory_done === 1'b1) begin
         ram[overide_address] <= overide_data_in;
         nwrites <= nwrites + 1;
      end
   end

   function automatic exp_t rest_e();
      exp_t e = '0;
      e.chk  = 1'b1;
      e.hold = m_err;
      e.err  = m_err;
      e.ww   = 10'(m_ww);
      return e;
   endfunction

   function automatic stim_t noise(bit allow_start);
      stim_t s;
      s.clr   = 1'b0;
      s.start = allow_start ? 1'($urandom_range(0, 1)) : 1'b0;
      s.base  = 9'($urandom);
      s.cnt   = 10'($urandom);
      s.vld   = 1'($urandom_range(0, 1));
      s.dat   = $urandom;
      s.done  = 1'($urandom_range(0, 1));
      return s;
   endfunction

   function automatic int hd(int i);
      return (i < hd_q.size()) ? hd_q[i] : int'($urandom_range(0, 2));
   endfunction

   function automatic int lt(int i);
      if (i < lat_q.size()) return lat_q[i];
      return ($urandom_range(0, 5) == 0) ? 14 : int'($urandom_range(0, 4));
   endfunction

   task automatic push(stim_t s, exp_t e);
      sq.push_back(s);
      eq.push_back(e);
   endtask

   task automatic do_clear(int n, exp_t first);
      exp_t z = '0;
      stim_t s;
      z.chk = 1'b1;
      for (int i = 0; i < n; i++) begin
         s = noise(1);
         s.clr = 1'b1;
         push(s, (i == 0) ? first : z);
      end
      m_err = 1'b0;
      m_ww  = 0;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) push(noise(0), rest_e());
   endtask

   // Timeline of one load: per word, hd(i) stalled accept cycles, one accepting cycle,
   // then lt(i) write cycles without done and one with done (lt >= TO means the RAM never answers).
   task automatic load(int base, int cnt, int abort_at);
      int          n;
      int          lat;
      exp_t        e;
      stim_t       s;
      logic [8:0]  a;
      logic [31:0] w;
      n = (cnt > 512) ? 512 : cnt;
      s = noise(0);
      s.start = 1'b1;
      s.base  = 9'(base);
      s.cnt   = 10'(cnt);
      push(s, rest_e());
      m_err = 1'b0;
      m_ww  = 0;
      if (n == 0) begin
         e = '0; e.chk = 1'b1; e.ld = 1'b1; e.hold = 1'b1;
         push(noise(1), e);
         return;
      end
      for (int i = 0; i < n; i++) begin
         e = '0; e.chk = 1'b1; e.rdy = 1'b1; e.hold = 1'b1; e.busy = 1'b1; e.ww = 10'(i);
         if (i == abort_at) begin
            do_clear(1, e);
            return;
         end
         w = (i < w_q.size()) ? w_q[i] : $urandom;
         for (int h = 0; h < hd(i); h++) begin
            s = noise(1); s.vld = 1'b0; push(s, e);
         end
         s = noise(1); s.vld = 1'b1; s.dat = w; push(s, e);
         a = 9'((base + i) % 512);
         e.rdy = 1'b0; e.mem = 1'b1; e.addr = a; e.data = w;
         lat = lt(i);
         if (lat >= TO) begin
            for (int k = 0; k < TO; k++) begin
               s = noise(1); s.done = 1'b0; push(s, e);
            end
            m_err = 1'b1;
            m_ww  = i;
            return;
         end
         for (int k = 0; k < lat; k++) begin
            s = noise(1); s.done = 1'b0; push(s, e);
         end
         s = noise(1); s.done = 1'b1; push(s, e);
         exp_ram[a] = w;
      end
      e = '0; e.chk = 1'b1; e.ld = 1'b1; e.hold = 1'b1; e.ww = 10'(n);
      push(noise(1), e);
      m_ww = n;
   endtask

   task automatic run();
      chk_en = 1'b1;
      for (int t = 0; t < sq.size(); t++) begin
         clear       = sq[t].clr;
         start       = sq[t].start;
         base_addr   = sq[t].base;
         word_count  = sq[t].cnt;
         in_valid    = sq[t].vld;
         in_data     = sq[t].dat;
         memory_done = sq[t].done;
         cur_exp     = eq[t];
         @(posedge clk);
         #1;
      end
      chk_en = 1'b0;
      sq.delete();
      eq.delete();
   endtask

   task automatic ram_image(string name);
      int bad = 0;
      for (int a = 0; a < 512; a++) if (ram[a] !== exp_ram[a]) bad++;
      check(name, 64'(bad), 64'd0);
   endtask

   task automatic reset_plan();
      hd_q.delete(); lat_q.delete(); w_q.delete();
   endtask

   initial begin
      exp_t  e0;
      int    ld0, nw0, mw0, cnt, abort_at;
      for (int i = 0; i < 512; i++) begin
         ram[i]     = 32'h5A5A_0000 | 32'(i);
         exp_ram[i] = 32'h5A5A_0000 | 32'(i);
      end
      clear = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
      in_valid = 1'b0; in_data = '0; memory_done = 1'b0;
      @(posedge clk);
      #1;

      // Reset with random inputs, including start.
      e0 = '0;
      do_clear(2, e0);
      idle(2);
      run();

      // Basic load.
      reset_plan();
      w_q = '{32'hDEADBEEF, 32'h0000_0001, 32'hCAFEF00D};
      lat_q = '{2, 2, 2};
      ld0 = ld_seen; nw0 = nwrites;
      load(9'h010, 3, -1);
      idle(3);
      run();
      check("basic_ram10", 64'(ram[9'h010]), 64'h0000_0000_DEADBEEF);
      check("basic_ram11", 64'(ram[9'h011]), 64'h0000_0000_0000_0001);
      check("basic_ram12", 64'(ram[9'h012]), 64'h0000_0000_CAFEF00D);
      check("basic_writes", 64'(nwrites - nw0), 64'd3);
      check("basic_done_pulses", 64'(ld_seen - ld0), 64'd1);
      check("basic_ww", 64'(words_written), 64'd3);
      ram_image("basic_ram_image");

      // Address wrap.
      reset_plan();
      w_q = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
      load(9'h1FE, 4, -1);
      idle(2);
      run();
      check("wrap_ram1fe", 64'(ram[9'h1FE]), 64'h1111_1111);
      check("wrap_ram1ff", 64'(ram[9'h1FF]), 64'h2222_2222);
      check("wrap_ram000", 64'(ram[9'h000]), 64'h3333_3333);
      check("wrap_ram001", 64'(ram[9'h001]), 64'h4444_4444);
      check("wrap_ram002", 64'(ram[9'h002]), 64'h5A5A_0002);

      // Host stall between words 1 and 2.
      reset_plan();
      hd_q = '{0, 5, 0};
      nw0 = nwrites;
      load(100, 3, -1);
      idle(2);
      run();
      check("stall_writes", 64'(nwrites - nw0), 64'd3);
      ram_image("stall_ram_image");

      // RAM never answers.
      reset_plan();
      lat_q = '{99};
      mw0 = mw_seen; nw0 = nwrites;
      load(200, 2, -1);
      idle(4);
      run();
      check("timeout_write_cycles", 64'(mw_seen - mw0), 64'd15);
      check("timeout_error", 64'(error), 64'd1);
      check("timeout_hold", 64'(cpu_hold), 64'd1);
      check("timeout_ww", 64'(words_written), 64'd0);
      check("timeout_writes", 64'(nwrites - nw0), 64'd0);
      reset_plan();
      load(200, 2, -1);
      idle(2);
      run();
      check("restart_error", 64'(error), 64'd0);
      check("restart_ww", 64'(words_written), 64'd2);

      // Clear after two of five words.
      reset_plan();
      nw0 = nwrites;
      load(300, 5, 2);
      idle(3);
      run();
      check("abort_writes", 64'(nwrites - nw0), 64'd2);
      check("abort_hold", 64'(cpu_hold), 64'd0);
      ram_image("abort_ram_image");

      // Zero-length load.
      reset_plan();
      ld0 = ld_seen; nw0 = nwrites; mw0 = mw_seen;
      load(50, 0, -1);
      idle(2);
      run();
      check("zero_done_pulses", 64'(ld_seen - ld0), 64'd1);
      check("zero_write_cycles", 64'(mw_seen - mw0), 64'd0);

      // Oversized count clamps to the full RAM.
      reset_plan();
      nw0 = nwrites;
      load(int'($urandom_range(0, 511)), 600, -1);
      idle(2);
      run();
      check("clamp_writes", 64'(nwrites - nw0), 64'd512);
      check("clamp_ww", 64'(words_written), 64'd512);
      ram_image("clamp_ram_image");

      // Random loads, restarts from error and aborts.
      for (int it = 0; it < 25; it++) begin
         reset_plan();
         cnt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
         for (int i = 0; i < cnt; i++) lat_q.push_back(lt(i));
         if (cnt > 0 && $urandom_range(0, 9) == 0) lat_q[$urandom_range(0, cnt - 1)] = 99;
         abort_at = (cnt > 1 && $urandom_range(0, 9) == 0) ? int'($urandom_range(1, cnt - 1)) : -1;
         load(int'($urandom_range(0, 511)), cnt, abort_at);
         idle(int'($urandom_range(0, 3)));
         run();
      end
      ram_image("final_ram_image");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
